// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit divider.
package div_pkg;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] DIVZ_Q    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement magnitude when signed, raw value otherwise.
  // 0x80000000 stays 0x80000000, which is correct read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step
  import div_pkg::*;
(
  input  logic [32:0] i_rem,
  input  logic        i_dvd_bit,
  input  logic [31:0] i_divisor,
  output logic [32:0] o_rem,
  output logic        o_q_bit
);

  logic [33:0] w_shift;
  logic [33:0] w_trial;

  // Shift in the next dividend bit and keep the trial difference only if it did not go negative.
  always_comb begin
    w_shift = {i_rem, i_dvd_bit};
    w_trial = w_shift - {2'b00, i_divisor};
    o_q_bit = ~w_trial[33];
    o_rem   = o_q_bit ? w_trial[32:0] : w_shift[32:0];
  end

endmodule

// File: rtl/div_32b_seq.sv
// Sequential 32-bit DIV/DIVU: quotient to LO (Q), remainder to HI (R).
//
// state | meaning
// IDLE  | waiting for start; accepts A/B/sign
// CALC  | one restoring step per clock, 32 steps on magnitudes
// FIX   | apply result signs and register Q/R
// DONE  | done pulse for one cycle, then back to IDLE
module div_32b_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  div_state_e  r_state;
  logic [32:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dvsr;
  logic [5:0]  r_count;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;
  logic [31:0] r_q;
  logic [31:0] r_r;

  logic [32:0] w_rem_next;
  logic        w_q_bit;

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign Q        = r_q;
  assign R        = r_r;

  // The dividend register doubles as the quotient: its MSB feeds the step, the new bit enters at the LSB.
  div_step u_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_dvd[31]),
    .i_divisor (r_dvsr),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Control FSM, step counter, sign fix-up and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvsr  <= '0;
      r_count <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (B == 32'd0) begin
              r_q     <= DIVZ_Q;
              r_r     <= A;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dvd   <= mag32(A, sign);
              r_dvsr  <= mag32(B, sign);
              r_qneg  <= sign & (A[31] ^ B[31]);
              r_rneg  <= sign & A[31];
              r_rem   <= '0;
              r_count <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem   <= w_rem_next;
          r_dvd   <= {r_dvd[30:0], w_q_bit};
          r_count <= r_count + 6'd1;
          if (r_count == 6'(DIV_STEPS - 1)) r_state <= FIX;
        end
        FIX: begin
          r_q     <= r_qneg ? (~r_dvd + 32'd1) : r_dvd;
          r_r     <= r_rneg ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32b_seq.sv
// Self-checking bench for div_32b_seq: cycle-level reference model plus directed literal checks.
module tb_div_32b_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_32b_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .R        (R),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: 64-bit signed division truncates toward zero, remainder takes dividend sign.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // Behavioural timing model: an accepted op finishes 33 edges later (1 for divide-by-zero),
  // and the block is back in idle one edge after the done cycle.
  logic        m_active, m_zero, m_busy, m_done, m_dz, chk_en;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          m_age, m_fin;

  initial begin
    chk_en   = 1'b0;
    m_active = 1'b0;
    m_zero   = 1'b0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_dz     = 1'b0;
    m_q      = '0;
    m_r      = '0;
    p_q      = '0;
    p_r      = '0;
    m_age    = 0;
    m_fin    = 0;
  end

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (rst) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_dz     = 1'b0;
      m_q      = '0;
      m_r      = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (!m_zero && m_age == 33) begin
          m_q    = p_q;
          m_r    = p_r;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
        if (m_age == m_fin) m_active = 1'b0;
      end else if (start) begin
        ref_div(sign, A, B, p_q, p_r);
        m_active = 1'b1;
        m_age    = 0;
        if (B == 32'd0) begin
          m_zero = 1'b1;
          m_fin  = 1;
          m_q    = p_q;
          m_r    = p_r;
          m_dz   = 1'b1;
          m_done = 1'b1;
        end else begin
          m_zero = 1'b0;
          m_fin  = 34;
          m_dz   = 1'b0;
          m_busy = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issue one op and follow it to done; optionally inject a stray start at edge index inj_at.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int inj_at,
                        output int done_e, output int busy_n,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
    @(negedge clk);
    start = 1'b1; sign = s; A = a; B = b;
    @(posedge clk);
    done_e = -1; busy_n = 0; q = '0; r = '0; dz = 1'b0;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (e == inj_at) begin
        start = 1'b1; A = 32'd5; B = 32'd5;
      end
      if (done) begin
        done_e = e; q = Q; r = R; dz = div_zero;
        break;
      end
      if (busy) busy_n++;
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  int          de, bn;
  logic [31:0] rq, rr;
  logic        rdz;

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          n_checks++;
          if ({busy, done, div_zero, Q, R} !== {m_busy, m_done, m_dz, m_q, m_r}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dz=%b Q=%h R=%h expected busy=%b done=%b dz=%b Q=%h R=%h",
                     $time, busy, done, div_zero, Q, R, m_busy, m_done, m_dz, m_q, m_r);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, div_zero, 2'b00}, 32'd0);
    check("reset_Q", Q, 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    run_op(1'b0, 32'd100, 32'd7, -1, de, bn, rq, rr, rdz);
    check("divu_100_7_done_edge", 32'(de), 32'd33);
    check("divu_100_7_busy_cycles", 32'(bn), 32'd33);
    check("divu_100_7_Q", rq, 32'd14);
    check("divu_100_7_R", rr, 32'd2);
    check("divu_100_7_dz", {31'd0, rdz}, 32'd0);
    idle_cycles(2);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, de, bn, rq, rr, rdz);
    check("div_m7_2_Q", rq, 32'hFFFF_FFFD);
    check("div_m7_2_R", rr, 32'hFFFF_FFFF);
    idle_cycles(2);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, de, bn, rq, rr, rdz);
    check("div_min_m1_Q", rq, 32'h8000_0000);
    check("div_min_m1_R", rr, 32'd0);
    idle_cycles(2);

    run_op(1'b1, 32'h8000_0000, 32'd1, -1, de, bn, rq, rr, rdz);
    check("div_min_1_Q", rq, 32'h8000_0000);
    idle_cycles(2);

    run_op(1'b0, 32'h1234_5678, 32'd0, -1, de, bn, rq, rr, rdz);
    check("divz_done_edge", 32'(de), 32'd0);
    check("divz_busy_cycles", 32'(bn), 32'd0);
    check("divz_Q", rq, 32'hFFFF_FFFF);
    check("divz_R", rr, 32'h1234_5678);
    check("divz_dz", {31'd0, rdz}, 32'd1);
    idle_cycles(2);

    run_op(1'b0, 32'd100, 32'd7, 10, de, bn, rq, rr, rdz);
    check("ignored_start_Q", rq, 32'd14);
    check("ignored_start_R", rr, 32'd2);
    check("ignored_start_dz", {31'd0, rdz}, 32'd0);
    idle_cycles(2);

    run_op(1'b0, 32'd5, 32'd9, -1, de, bn, rq, rr, rdz);
    check("divu_b_gt_a_Q", rq, 32'd0);
    check("divu_b_gt_a_R", rr, 32'd5);
    idle_cycles(2);

    // Reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1; sign = 1'b0; A = 32'd1000; B = 32'd3;
    @(posedge clk);
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midcalc_rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    check("midcalc_rst_Q", Q, 32'd0);
    check("midcalc_rst_R", R, 32'd0);
    rst = 1'b0;
    idle_cycles(1);

    run_op(1'b0, 32'd9, 32'd3, -1, de, bn, rq, rr, rdz);
    check("after_rst_9_3_done_edge", 32'(de), 32'd33);
    check("after_rst_9_3_Q", rq, 32'd3);
    check("after_rst_9_3_R", rr, 32'd0);
    idle_cycles(2);

    // Random sweep: inputs change every cycle, start is usually high, so ignored and back-to-back starts occur.
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      start = ($urandom % 4) != 0;
      sign  = 1'($urandom % 2);
      case ($urandom % 6)
        0:       A = 32'd0;
        1:       A = 32'h8000_0000;
        2:       A = $urandom % 100;
        default: A = $urandom;
      endcase
      case ($urandom % 10)
        0:       B = 32'd0;
        1:       B = 32'd1;
        2:       B = A;
        3:       B = A + 32'd1 + ($urandom % 1000);
        4:       B = 32'hFFFF_FFFF;
        5:       B = $urandom % 16;
        default: B = $urandom;
      endcase
      rst = ($urandom % 3000) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
